// File: rtl/dct_quant_reader.sv
// Read master for the avalon_dct result port: fetches coefficients 0..size-1, quantizes each one
// (rounded shift, signed saturation) and streams them out. Optional DCT_QUANT_SAT_COUNT_EN builds the saturation counter.
module dct_quant_reader #(
  parameter int MAX_SIZE = 256,
  parameter int NBITS    = 16,
  parameter int OBITS    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [$clog2(MAX_SIZE):0]     size,
  input  logic [3:0]                    shift,
  output logic [7:0]                    dct_address,
  output logic                          dct_read,
  input  logic signed [NBITS-1:0]       dct_data,
  input  logic                          dct_done,
  output logic [OBITS-1:0]              q_data,
  output logic                          q_valid,
  input  logic                          q_ready,
  output logic                          q_last,
  output logic                          busy,
  output logic [15:0]                   sat_count
);

  localparam int SW = $clog2(MAX_SIZE) + 1;
  localparam logic signed [NBITS:0] QMAX = (NBITS+1)'((1 << (OBITS-1)) - 1);
  localparam logic signed [NBITS:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_size;
  logic [SW-1:0]    r_idx;
  logic [3:0]       r_shift;
  logic [7:0]       r_dctAddress;
  logic             r_dctRead;
  logic [OBITS-1:0] r_qData;
  logic             r_qValid;
  logic             r_qLast;
  logic             r_busy;

  logic signed [NBITS:0] w_x;
  logic signed [NBITS:0] w_bias;
  logic signed [NBITS:0] w_sum;
  logic signed [NBITS:0] w_t;
  logic                  w_hi;
  logic                  w_lo;
  logic [OBITS-1:0]      w_q;
  logic [SW-1:0]         w_clampedSize;
  logic                  w_startRun;

  // One extra bit of headroom keeps the rounding bias from overflowing before the shift.
  assign w_x    = {dct_data[NBITS-1], dct_data};
  assign w_bias = (r_shift == 4'd0) ? '0 : ((NBITS+1)'(1) << (r_shift - 4'd1));
  assign w_sum  = w_x + w_bias;
  assign w_t    = w_sum >>> r_shift;
  assign w_hi   = (w_t > QMAX);
  assign w_lo   = (w_t < QMIN);
  assign w_q    = w_hi ? QMAX[OBITS-1:0] : (w_lo ? QMIN[OBITS-1:0] : w_t[OBITS-1:0]);

  assign w_clampedSize = (size > SW'(MAX_SIZE)) ? SW'(MAX_SIZE) : size;
  assign w_startRun    = (r_state == IDLE) && start && (size != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_dctAddress <= '0;
      r_dctRead    <= 1'b0;
      r_qData      <= '0;
      r_qValid     <= 1'b0;
      r_qLast      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startRun) begin
            r_size       <= w_clampedSize;
            r_shift      <= shift;
            r_idx        <= '0;
            r_dctAddress <= '0;
            r_dctRead    <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= READ;
          end
        end
        READ: begin
          if (dct_done) begin
            r_qData   <= w_q;
            r_qValid  <= 1'b1;
            r_qLast   <= (r_idx == r_size - SW'(1));
            r_dctRead <= 1'b0;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          if (r_qValid && q_ready) begin
            r_qValid <= 1'b0;
            if (r_qLast) begin
              r_qLast <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx        <= r_idx + SW'(1);
              r_dctAddress <= 8'(r_idx + SW'(1));
              r_dctRead    <= 1'b1;
              r_state      <= READ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DCT_QUANT_SAT_COUNT_EN
  logic        w_sat;
  logic [15:0] r_satCount;

  assign w_sat = w_hi | w_lo;

  // Counts clamped coefficients of the current run, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_satCount <= '0;
    end else if (w_startRun) begin
      r_satCount <= '0;
    end else if ((r_state == READ) && dct_done && w_sat && (r_satCount != 16'hFFFF)) begin
      r_satCount <= r_satCount + 16'd1;
    end
  end

  assign sat_count = r_satCount;
`else
  assign sat_count = '0;
`endif

  assign dct_address = r_dctAddress;
  assign dct_read    = r_dctRead;
  assign q_data      = r_qData;
  assign q_valid     = r_qValid;
  assign q_last      = r_qLast;
  assign busy        = r_busy;

endmodule

// File: tb/tb_dct_quant_reader.sv
// Testbench for dct_quant_reader: models the DCT read port and a stalling consumer, and scoreboards
// every quantized output against an integer reference model.
module tb_dct_quant_reader;

  localparam int MAX_SIZE = 256;
  localparam int NBITS    = 16;
  localparam int OBITS    = 8;
`ifdef DCT_QUANT_SAT_COUNT_EN
  localparam int SAT_EXP = 2;
`else
  localparam int SAT_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [8:0]        size;
  logic [3:0]        shift;
  logic [7:0]        dct_address;
  logic              dct_read;
  logic signed [15:0] dct_data;
  logic              dct_done;
  logic [7:0]        q_data;
  logic              q_valid;
  logic              q_ready;
  logic              q_last;
  logic              busy;
  logic [15:0]       sat_count;

  int nTests = 0;
  int nFail  = 0;

  logic signed [15:0] mem [256];
  logic [8:0]         expQ[$];
  int                 addrLog[$];
  int  doneStall, readyStall, stallCnt, readyCnt, hsCount, lastCount, curShift, effSize, expSat;
  logic [7:0] lastAddr;
  logic [7:0] lastQ;
  logic       lastFlag;

  dct_quant_reader #(.MAX_SIZE(MAX_SIZE), .NBITS(NBITS), .OBITS(OBITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .shift(shift),
    .dct_address(dct_address), .dct_read(dct_read), .dct_data(dct_data), .dct_done(dct_done),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready), .q_last(q_last),
    .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  function automatic int rawT(input int x, input int sh);
    if (sh > 0) return (x + (1 << (sh - 1))) >>> sh;
    return x;
  endfunction

  // One clock: at the falling edge play the DCT slave and the consumer, scoreboarding each handshake.
  task automatic stepCycle();
    int t;
    int q;
    logic [8:0] e;
    @(negedge clk);
    if (dct_read === 1'b1) begin
      if (stallCnt == 0) begin
        lastAddr = dct_address;
        addrLog.push_back(int'(dct_address));
      end else begin
        nTests++;
        if (dct_address !== lastAddr) begin
          nFail++;
          $display("[TB] FAIL addr_stable: got %0d expected %0d", dct_address, lastAddr);
        end
      end
      if (stallCnt >= doneStall) begin
        dct_done = 1'b1;
        dct_data = mem[dct_address];
        t = rawT(int'(mem[dct_address]), curShift);
        q = (t > 127) ? 127 : ((t < -128) ? -128 : t);
        if (t > 127 || t < -128) expSat++;
        expQ.push_back({(int'(dct_address) == effSize - 1), 8'(q)});
        stallCnt = 0;
      end else begin
        dct_done = 1'b0;
        dct_data = 16'($urandom);
        stallCnt++;
      end
    end else begin
      dct_done = 1'($urandom_range(0, 1));
      dct_data = 16'($urandom);
      stallCnt = 0;
    end
    if (q_valid === 1'b1) begin
      if (readyCnt >= readyStall) begin
        q_ready  = 1'b1;
        readyCnt = 0;
        hsCount++;
        if (q_last === 1'b1) lastCount++;
        lastQ    = q_data;
        lastFlag = q_last;
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL scoreboard_empty: got data %h last %b, expected no output", q_data, q_last);
        end else begin
          e = expQ.pop_front();
          if ({q_last, q_data} !== e) begin
            nFail++;
            $display("[TB] FAIL scoreboard: got last %b data %h expected last %b data %h",
                     q_last, q_data, e[8], e[7:0]);
          end
        end
      end else begin
        q_ready = 1'b0;
        readyCnt++;
      end
    end else begin
      q_ready = 1'b0;
    end
  endtask

  task automatic startRun(input int sz, input int sh, input int dS, input int rS, input string name);
    effSize    = (sz > MAX_SIZE) ? MAX_SIZE : sz;
    curShift   = sh;
    doneStall  = dS;
    readyStall = rS;
    hsCount    = 0;
    lastCount  = 0;
    expSat     = 0;
    stallCnt   = 0;
    readyCnt   = 0;
    addrLog.delete();
    expQ.delete();
    size  = 9'(sz);
    shift = 4'(sh);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    nTests++;
    if (dct_read !== 1'b1 || busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s_start: got read %b busy %b expected 1 1", name, dct_read, busy);
    end
  endtask

  task automatic finishRun(input string name, input bit poke);
    int  bound;
    int  cyc;
    bit  ok;
    bound = effSize * (doneStall + readyStall + 4) + 20;
    cyc   = 0;
    while (!(hsCount == effSize && busy === 1'b0) && cyc < bound) begin
      if (poke && cyc == 3) begin
        start = 1'b1;
        size  = 9'd1;
        shift = 4'd0;
      end else begin
        start = 1'b0;
      end
      stepCycle();
      cyc++;
    end
    start = 1'b0;
    nTests++;
    if (cyc >= bound) begin
      nFail++;
      $display("[TB] FAIL %s_timeout: got %0d handshakes after %0d cycles expected %0d", name, hsCount, cyc, effSize);
    end
    nTests++;
    if (hsCount != effSize || lastCount != 1 || expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL %s_count: got hs %0d last %0d pending %0d expected %0d 1 0",
               name, hsCount, lastCount, expQ.size(), effSize);
    end
    ok = (addrLog.size() == effSize);
    foreach (addrLog[i]) if (addrLog[i] != i) ok = 0;
    nTests++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL %s_addr: got %0d reads expected sequence 0..%0d", name, addrLog.size(), effSize - 1);
    end
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s_idle: got busy %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    size    = '0;
    shift   = '0;
    q_ready = 1'b0;
    dct_done = 1'b0;
    dct_data = '0;
    repeat (2) stepCycle();
    nTests++;
    if ({dct_read, dct_address, q_data, q_valid, q_last, busy, sat_count} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset: got read %b addr %h q %h valid %b last %b busy %b sat %h expected all 0",
               dct_read, dct_address, q_data, q_valid, q_last, busy, sat_count);
    end
    reset_n = 1'b1;
    stepCycle();
  endtask

  task automatic test_basic_rounding();
    mem[0] = 16'sd291;
    startRun(1, 4, 0, 0, "basic");
    finishRun("basic", 1'b0);
    nTests++;
    if (lastQ !== 8'h12 || lastFlag !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL basic_value: got %h last %b expected 12 1", lastQ, lastFlag);
    end
  endtask

  task automatic test_negative_rounding();
    mem[0] = -16'sd291;
    startRun(1, 4, 0, 0, "negative");
    finishRun("negative", 1'b0);
    nTests++;
    if (lastQ !== 8'hEE) begin
      nFail++;
      $display("[TB] FAIL negative_value: got %h expected ee", lastQ);
    end
  endtask

  task automatic test_saturation();
    mem[0] = 16'sh7FFF;
    mem[1] = 16'sh8000;
    startRun(2, 0, 0, 0, "saturation");
    finishRun("saturation", 1'b0);
    nTests++;
    if (lastQ !== 8'h80 || sat_count !== 16'(SAT_EXP)) begin
      nFail++;
      $display("[TB] FAIL saturation_value: got q %h sat %0d expected 80 %0d", lastQ, sat_count, SAT_EXP);
    end
  endtask

  task automatic test_stall_backpressure();
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    startRun(4, 5, 3, 2, "stall");
    finishRun("stall", 1'b1);
  endtask

  task automatic test_size_zero();
    bit ok;
    ok      = 1;
    hsCount = 0;
    size    = 9'd0;
    start   = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (8) begin
      if (busy !== 1'b0 || dct_read !== 1'b0) ok = 0;
      stepCycle();
    end
    nTests++;
    if (!ok || hsCount != 0) begin
      nFail++;
      $display("[TB] FAIL size_zero: got busy %b read %b hs %0d expected 0 0 0", busy, dct_read, hsCount);
    end
  endtask

  task automatic test_max_size();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    startRun(300, 3, 0, 0, "max_size");
    finishRun("max_size", 1'b0);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit ok;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    startRun(8, 2, 0, 5, "midrun");
    cyc = 0;
    while (!(hsCount == 2 && q_valid === 1'b1 && readyCnt == 1) && cyc < 200) begin
      stepCycle();
      cyc++;
    end
    nTests++;
    if (cyc >= 200) begin
      nFail++;
      $display("[TB] FAIL midrun_reach: got hs %0d expected HOLD of index 2", hsCount);
    end
    reset_n = 1'b0;
    stepCycle();
    nTests++;
    if ({dct_read, dct_address, q_data, q_valid, q_last, busy, sat_count} !== '0) begin
      nFail++;
      $display("[TB] FAIL midrun_reset: got read %b addr %h q %h valid %b last %b busy %b sat %h expected all 0",
               dct_read, dct_address, q_data, q_valid, q_last, busy, sat_count);
    end
    reset_n = 1'b1;
    expQ.delete();
    ok = 1;
    repeat (4) begin
      stepCycle();
      if (q_valid !== 1'b0 || q_last !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    nTests++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL midrun_quiet: got valid %b last %b busy %b expected 0 0 0", q_valid, q_last, busy);
    end
    startRun(2, 1, 0, 0, "after_reset");
    finishRun("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_rounding();
    test_negative_rounding();
    test_saturation();
    test_stall_backpressure();
    test_size_zero();
    test_max_size();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
